logic_unit_pipe: RTL and testbench



---
 rtl/logic_unit_pipe.sv | 159 +++++++++++++++
 tb/tb_logic_unit_pipe.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// ---------------------------------------------------------------------------
// logic_unit_pipe
//
// Two-stage pipelined bitwise logic unit. It takes operand pairs over a
// valid/ready handshake, applies one of eight bitwise operations selected by
// a 3-bit opcode, and returns a registered result with zero and parity flags.
// It also keeps a saturating count of completed output handshakes.
//
// Pipeline:
//   S1 : registers a, b and opcode on an input handshake.
//   S2 : computes the result from S1 and registers result, flags and valid.
//   With S2 free, a handshake at edge N gives out_valid high after edge N+1.
//   Throughput is one operation per cycle while out_ready is high.
//
// Parameters:
//   WIDTH      operand/result width in bits (>= 1)
//   CNT_W      width of the completed-operation counter (>= 1)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous, active-low reset
//   in_valid   operand pair and opcode presented
//   in_ready   block can accept this cycle (combinational from state and
//              out_ready only, never from in_valid)
//   opcode     operation select:
//                000 AND    001 OR     010 XOR    011 NOR
//                100 NAND   101 XNOR   110 NOT A  111 A AND NOT B
//   a, b       operands
//   out_valid  result presented (registered)
//   out_ready  consumer accepts result
//   out_result operation result (registered)
//   out_zero   out_result == 0 (registered)
//   out_parity XOR-reduce of out_result (registered)
//   count_clr  synchronous clear of op_count; wins over a same-cycle count
//   op_count   saturating count of output handshakes (registered)
// ---------------------------------------------------------------------------
module logic_unit_pipe #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_parity,
  input  logic             count_clr,
  output logic [CNT_W-1:0] op_count
);

  // Opcode encoding; all eight codes are real operations.
  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NOR  = 3'b011,
    OP_NAND = 3'b100,
    OP_XNOR = 3'b101,
    OP_NOTA = 3'b110,
    OP_ANDN = 3'b111
  } op_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Stage 1 holding registers
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  op_e              s1_op;

  // Stage 2 handshake and the combinational result feeding its registers
  logic             s2_ready;
  logic [WIDTH-1:0] s2_result;
  logic             out_fire;

  // Flow control. S2 can take new data when it is empty or its result is
  // leaving this cycle; S1 can take new data when it is empty or can pass
  // its contents to S2. When out_ready rises while both stages are full,
  // in_ready rises in the same cycle so S1 and S2 both move on that edge
  // without a bubble.
  assign s2_ready = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_ready;
  assign out_fire = out_valid && out_ready;

  // Result selection from S1 contents. The default assignment only keeps
  // the block latch-free; every opcode value has its own explicit arm.
  always_comb begin
    s2_result = '0;
    unique case (s1_op)
      OP_AND:  s2_result = s1_a & s1_b;
      OP_OR:   s2_result = s1_a | s1_b;
      OP_XOR:  s2_result = s1_a ^ s1_b;
      OP_NOR:  s2_result = ~(s1_a | s1_b);
      OP_NAND: s2_result = ~(s1_a & s1_b);
      OP_XNOR: s2_result = ~(s1_a ^ s1_b);
      OP_NOTA: s2_result = ~s1_a;
      OP_ANDN: s2_result = s1_a & ~s1_b;
    endcase
  end

  // Stage 1. Loaded whenever in_ready is high; if nothing is offered at that
  // point s1_valid clears, which is how S1 empties after handing data to S2.
  // Operand registers only change on an actual handshake so that a, b and
  // opcode may wander freely between transfers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_AND;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a  <= a;
        s1_b  <= b;
        s1_op <= op_e'(opcode);
      end
    end
  end

  // Stage 2 / output registers. When S2 can accept, out_valid follows
  // s1_valid. Result and flags are only rewritten when real data arrives,
  // so during a stall (out_valid && !out_ready) they stay perfectly stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b0;
      out_parity <= 1'b0;
    end else if (s2_ready) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= s2_result;
        out_zero   <= (s2_result == '0);
        out_parity <= ^s2_result;
      end
    end
  end

  // Completed-operation counter. Counts output handshakes, sticks at its
  // maximum instead of wrapping, and a clear takes priority over a count
  // landing in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (count_clr) begin
      op_count <= '0;
    end else if (out_fire && (op_count != CNT_MAX)) begin
      op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// ---------------------------------------------------------------------------
// tb_logic_unit_pipe
//
// Directed testbench for logic_unit_pipe. A default instance (WIDTH=32,
// CNT_W=16) covers the opcode stream, flags, backpressure and mid-stream
// reset; a narrow instance (WIDTH=8, CNT_W=3) covers the width generic,
// counter saturation and clear-versus-count priority.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_logic_unit_pipe;

  logic        clk;
  logic        rst_n;

  // Default instance signals
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  opcode;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_parity;
  logic        count_clr;
  logic [15:0] op_count;

  // Narrow instance signals
  logic        n_in_valid;
  logic        n_in_ready;
  logic [2:0]  n_opcode;
  logic [7:0]  n_a;
  logic [7:0]  n_b;
  logic        n_out_valid;
  logic        n_out_ready;
  logic [7:0]  n_out_result;
  logic        n_out_zero;
  logic        n_out_parity;
  logic        n_count_clr;
  logic [2:0]  n_op_count;

  int n_checks;
  int n_fail;

  logic [31:0] exp_tab [8];

  logic_unit_pipe #(.WIDTH(32), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opcode     (opcode),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_parity (out_parity),
    .count_clr  (count_clr),
    .op_count   (op_count)
  );

  logic_unit_pipe #(.WIDTH(8), .CNT_W(3)) dut_narrow (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (n_in_valid),
    .in_ready   (n_in_ready),
    .opcode     (n_opcode),
    .a          (n_a),
    .b          (n_b),
    .out_valid  (n_out_valid),
    .out_ready  (n_out_ready),
    .out_result (n_out_result),
    .out_zero   (n_out_zero),
    .out_parity (n_out_parity),
    .count_clr  (n_count_clr),
    .op_count   (n_op_count)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 ns before driving/sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation to the default instance
  task automatic applyStimulus(input logic v, input logic [2:0] op,
                               input logic [31:0] va, input logic [31:0] vb);
    in_valid = v;
    opcode   = op;
    a        = va;
    b        = vb;
  endtask

  // One counted comparison
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_tab[0] = 32'hF000F000;
    exp_tab[1] = 32'hFFF0FFF0;
    exp_tab[2] = 32'h0FF00FF0;
    exp_tab[3] = 32'h000F000F;
    exp_tab[4] = 32'h0FFF0FFF;
    exp_tab[5] = 32'hF00FF00F;
    exp_tab[6] = 32'h0F0F0F0F;
    exp_tab[7] = 32'h00F000F0;

    rst_n       = 1'b0;
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0);
    out_ready   = 1'b0;
    count_clr   = 1'b0;
    n_in_valid  = 1'b0;
    n_opcode    = 3'd0;
    n_a         = 8'h00;
    n_b         = 8'h00;
    n_out_ready = 1'b0;
    n_count_clr = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    checkOutput("rst_out_valid",  {31'b0, out_valid},  32'd0);
    checkOutput("rst_out_result", out_result,          32'd0);
    checkOutput("rst_out_zero",   {31'b0, out_zero},   32'd0);
    checkOutput("rst_out_parity", {31'b0, out_parity}, 32'd0);
    checkOutput("rst_op_count",   {16'b0, op_count},   32'd0);
    checkOutput("rst_in_ready",   {31'b0, in_ready},   32'd1);

    // ---------------- all eight opcodes back to back ----------------
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) applyStimulus(1'b1, i[2:0], 32'hF0F0F0F0, 32'hFF00FF00);
      else       applyStimulus(1'b0, 3'd0, 32'h0, 32'h0);
      tick();
      if (i >= 1 && i <= 8) begin
        checkOutput($sformatf("stream_valid_%0d", i - 1), {31'b0, out_valid}, 32'd1);
        checkOutput($sformatf("stream_result_%0d", i - 1), out_result, exp_tab[i - 1]);
      end
    end
    checkOutput("stream_drained", {31'b0, out_valid}, 32'd0);
    checkOutput("stream_count",   {16'b0, op_count},  32'd8);

    // ---------------- zero / parity flags ----------------
    applyStimulus(1'b1, 3'b010, 32'h12345678, 32'h12345678);
    tick();
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0);
    tick();
    checkOutput("xor_self_valid",  {31'b0, out_valid},  32'd1);
    checkOutput("xor_self_result", out_result,          32'd0);
    checkOutput("xor_self_zero",   {31'b0, out_zero},   32'd1);
    checkOutput("xor_self_parity", {31'b0, out_parity}, 32'd0);
    applyStimulus(1'b1, 3'b001, 32'h1, 32'h0);
    tick();
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0);
    tick();
    checkOutput("or_one_result", out_result,          32'd1);
    checkOutput("or_one_zero",   {31'b0, out_zero},   32'd0);
    checkOutput("or_one_parity", {31'b0, out_parity}, 32'd1);
    tick();
    count_clr = 1'b1;
    tick();
    count_clr = 1'b0;
    checkOutput("clr_count", {16'b0, op_count}, 32'd0);

    // ---------------- backpressure ----------------
    out_ready = 1'b0;
    applyStimulus(1'b1, 3'd0, 32'hF0F0F0F0, 32'hFF00FF00);
    tick();
    checkOutput("bp_ready_after_1", {31'b0, in_ready}, 32'd1);
    applyStimulus(1'b1, 3'd1, 32'hF0F0F0F0, 32'hFF00FF00);
    tick();
    applyStimulus(1'b1, 3'd2, 32'hF0F0F0F0, 32'hFF00FF00);
    checkOutput("bp_ready_after_2", {31'b0, in_ready}, 32'd0);
    checkOutput("bp_first_result",  out_result,        exp_tab[0]);
    repeat (2) tick();
    checkOutput("bp_hold_valid",  {31'b0, out_valid}, 32'd1);
    checkOutput("bp_hold_result", out_result,         exp_tab[0]);
    checkOutput("bp_hold_ready",  {31'b0, in_ready},  32'd0);
    checkOutput("bp_hold_count",  {16'b0, op_count},  32'd0);
    out_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", {31'b0, in_ready}, 32'd1);
    tick();
    checkOutput("bp_out_1", out_result, exp_tab[1]);
    applyStimulus(1'b1, 3'd3, 32'hF0F0F0F0, 32'hFF00FF00);
    tick();
    checkOutput("bp_out_2", out_result, exp_tab[2]);
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0);
    tick();
    checkOutput("bp_out_3",       out_result,         exp_tab[3]);
    checkOutput("bp_out_3_valid", {31'b0, out_valid}, 32'd1);
    tick();
    checkOutput("bp_end_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("bp_end_count", {16'b0, op_count},  32'd4);

    // ---------------- reset mid-stream ----------------
    out_ready = 1'b0;
    applyStimulus(1'b1, 3'd0, 32'hF0F0F0F0, 32'hFF00FF00);
    tick();
    applyStimulus(1'b1, 3'd1, 32'hF0F0F0F0, 32'hFF00FF00);
    tick();
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0);
    checkOutput("mid_pre_valid", {31'b0, out_valid}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("mid_valid",  {31'b0, out_valid},  32'd0);
    checkOutput("mid_result", out_result,          32'd0);
    checkOutput("mid_zero",   {31'b0, out_zero},   32'd0);
    checkOutput("mid_parity", {31'b0, out_parity}, 32'd0);
    checkOutput("mid_count",  {16'b0, op_count},   32'd0);
    checkOutput("mid_ready",  {31'b0, in_ready},   32'd1);
    out_ready = 1'b1;
    repeat (2) tick();
    checkOutput("mid_no_ghost_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("mid_no_ghost_count", {16'b0, op_count},  32'd0);
    applyStimulus(1'b1, 3'b001, 32'hA, 32'h5);
    tick();
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0);
    tick();
    checkOutput("mid_new_valid",  {31'b0, out_valid},  32'd1);
    checkOutput("mid_new_result", out_result,          32'hF);
    checkOutput("mid_new_parity", {31'b0, out_parity}, 32'd0);
    tick();

    // ---------------- narrow width, saturation, clear priority ----------------
    n_out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      n_in_valid = (i < 10);
      n_opcode   = 3'b110;
      n_a        = 8'h3C;
      n_b        = 8'hFF;
      tick();
      if (i == 1) begin
        checkOutput("n_nota_result", {24'b0, n_out_result}, 32'h000000C3);
        checkOutput("n_nota_parity", {31'b0, n_out_parity}, 32'd0);
      end
    end
    checkOutput("n_sat_count", {29'b0, n_op_count}, 32'd7);
    n_count_clr = 1'b1;
    tick();
    n_count_clr = 1'b0;
    checkOutput("n_clr_count", {29'b0, n_op_count}, 32'd0);
    n_in_valid = 1'b1;
    n_opcode   = 3'b000;
    n_a        = 8'hAA;
    n_b        = 8'h0F;
    tick();
    n_in_valid = 1'b0;
    tick();
    checkOutput("n_pre_clr_valid",  {31'b0, n_out_valid},  32'd1);
    checkOutput("n_pre_clr_result", {24'b0, n_out_result}, 32'h0000000A);
    n_count_clr = 1'b1;
    tick();
    n_count_clr = 1'b0;
    checkOutput("n_clr_wins", {29'b0, n_op_count}, 32'd0);
    checkOutput("n_clr_hs_done", {31'b0, n_out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
